// File: rtl/scrambler.sv
// scrambler: additive scrambler, LFSR x^7 + x^4 + 1 (802.11 OFDM data path).
// Processes WIDTH bits per accepted AXI4-Stream beat, bit 0 first; also descrambles.
// Optional feature: define SCRAMBLER_RESEED_ON_LAST_EN to reload SEED after every
// beat carrying s_axis_tlast, so each packet starts from SEED.
// Reset (aresetn) is asynchronous and active-high despite its name.
module scrambler #(
    parameter int unsigned WIDTH = 24,
    parameter logic [6:0]  SEED  = 7'b1011101
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    localparam int unsigned LFSR_W = 7;

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] state_next;
    logic [LFSR_W-1:0] lfsr_walk;
    logic              fb;
    logic [WIDTH-1:0]  din_shift;
    logic [WIDTH:0]    scr_shift;
    logic [WIDTH-1:0]  scr_data;
    logic              accept;

    // Upstream may push whenever the output register is empty or being drained.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Unrolled WIDTH-step LFSR walk; scrambled bits shift in from the top so bit 0 lands lowest.
    always_comb begin
        lfsr_walk = state;
        din_shift = s_axis_tdata;
        scr_shift = '0;
        fb        = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            fb        = lfsr_walk[6] ^ lfsr_walk[3];
            scr_shift = {din_shift[0] ^ fb, scr_shift[WIDTH:1]};
            din_shift = din_shift >> 1;
            lfsr_walk = {lfsr_walk[5:0], fb};
        end
        scr_data = scr_shift[WIDTH:1];
    end

    // Next LFSR state: advance only on an accepted beat, optionally restart at packet end.
    always_comb begin
        state_next = state;
        if (accept) begin
`ifdef SCRAMBLER_RESEED_ON_LAST_EN
            state_next = s_axis_tlast ? SEED : lfsr_walk;
`else
            state_next = lfsr_walk;
`endif
        end
    end

    // LFSR state register.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state <= SEED;
        end else begin
            state <= state_next;
        end
    end

    // Output register stage: load on accept, otherwise clear valid once consumed.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= scr_data;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scrambler.sv
// tb_scrambler: scoreboard bench for scrambler. Expected beats are queued at accept
// time from a bit-recurrence model (seq[n] = seq[n-7] ^ seq[n-4]) seeded from SEED;
// a negedge monitor pops and compares every delivered beat.
module tb_scrambler;

    localparam int unsigned W    = 24;
    localparam logic [6:0]  SEED = 7'b1011101;
    localparam int          PER  = 127;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;

    int           checks = 0;
    int           errors = 0;
    int           ptr = 0;
    logic         xs [0:PER+6];
    beat_t        exp_q [$];
    logic [W-1:0] cap_q [$];
    logic [W-1:0] t1w [0:2];
    logic [W-1:0] vec [0:9];
    logic [W-1:0] fbw [0:9];
    logic         bp_done;

    always #5 aclk = ~aclk;

    scrambler #(.WIDTH(W), .SEED(SEED)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Monitor: every delivered beat is checked against the head of the scoreboard.
    always @(negedge aclk) begin
        beat_t e;
        if (!aresetn && m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got %h/%b with empty scoreboard", m_axis_tdata, m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
                    errors++;
                    $display("FAIL beat got %h/%b want %h/%b", m_axis_tdata, m_axis_tlast, e.d, e.l);
                end
            end
            cap_q.push_back(m_axis_tdata);
        end
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [W-1:0] seq_word(input int p);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(W); k++) w[k] = xs[7 + ((p + k) % PER)];
        return w;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic chk_diff(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        checks++;
        if (a === b) begin
            errors++;
            $display("FAIL %s got %h equal to %h, want different", name, a, b);
        end
    endtask

    // Present one beat, queue its expected output when accepted, release after the edge.
    task automatic send(input logic [W-1:0] d, input logic l, input logic use_e, input logic [W-1:0] e);
        int    n;
        beat_t b;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge aclk);
            if (s_axis_tready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout s_axis_tready stuck 0 want 1");
                break;
            end
        end
        b.d = use_e ? e : (d ^ seq_word(ptr));
        b.l = l;
        exp_q.push_back(b);
        ptr = (ptr + int'(W)) % PER;
`ifdef SCRAMBLER_RESEED_ON_LAST_EN
        if (l) ptr = 0;
`endif
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_m(input logic [W-1:0] d, input logic l);
        send(d, l, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        exp_q.delete();
        cap_q.delete();
        ptr = 0;
    endtask

    initial begin
        int n;
        logic [W-1:0] held;

        // Reference bit stream: xs[0..6] hold seq[-7..-1] = s6..s0.
        for (int i = 0; i < 7; i++) xs[i] = SEED[6 - i];
        for (int i = 7; i < PER + 7; i++) xs[i] = xs[i - 7] ^ xs[i - 4];

        vec[0] = 24'h000000; vec[1] = 24'hFFFFFF; vec[2] = 24'hA5A5A5; vec[3] = 24'h5A5A5A;
        vec[4] = 24'h123456; vec[5] = 24'h654321; vec[6] = 24'h800001; vec[7] = 24'h0F0F0F;
        vec[8] = 24'hDEADBE; vec[9] = 24'h000001;

        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        bp_done       = 1'b0;

        // Reset state.
        idle(3);
        chk("rst_m_tvalid", W'(m_axis_tvalid), '0);
        chk("rst_m_tdata", m_axis_tdata, '0);
        chk("rst_m_tlast", W'(m_axis_tlast), '0);
        chk("rst_s_tready", W'(s_axis_tready), W'(1));
        aresetn = 1'b0;
        idle(1);

        // Raw sequence: three zero words.
        for (int i = 0; i < 3; i++) send_m('0, 1'b0);
        drain();
        chk("raw_count", W'(cap_q.size()), W'(3));
        if (cap_q.size() == 3) begin
            chk("raw_first_byte", W'(cap_q[0][7:0]), W'(8'h36));
            for (int i = 0; i < 3; i++) t1w[i] = cap_q[i];
        end

        // Ten data words, then feed the outputs back to recover the inputs.
        do_reset();
        for (int i = 0; i < 10; i++) send_m(vec[i], i == 9);
        drain();
        chk("data_count", W'(cap_q.size()), W'(10));
        for (int i = 0; i < 10; i++) fbw[i] = (i < cap_q.size()) ? cap_q[i] : '0;
        do_reset();
        for (int i = 0; i < 10; i++) send(fbw[i], i == 9, 1'b1, vec[i]);
        drain();

        // Backpressure: output held for three cycles.
        do_reset();
        m_axis_tready = 1'b0;
        fork
            begin
                send_m(24'h111111, 1'b0);
                send_m(24'h222222, 1'b0);
                send_m(24'h333333, 1'b1);
                bp_done = 1'b1;
            end
        join_none
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!m_axis_tvalid && n < 20);
        held = m_axis_tdata;
        chk("bp_held_word", held, 24'h111111 ^ seq_word(0));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge aclk);
            chk("bp_s_tready", W'(s_axis_tready), '0);
            chk("bp_m_tvalid", W'(m_axis_tvalid), W'(1));
            chk("bp_m_tdata_stable", m_axis_tdata, held);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        n = 0;
        while (!bp_done && n < 100) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("bp_done", W'(bp_done), W'(1));
        drain();

        // Input gaps: must match the gapless raw run.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_m('0, 1'b0);
            idle(2);
        end
        drain();
        if (cap_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("gap_vs_gapless", cap_q[i], t1w[i]);
        end else begin
            chk("gap_count", W'(cap_q.size()), W'(3));
        end

        // Reset mid-stream drops the held beat and restarts from SEED.
        do_reset();
        send_m('0, 1'b0);
        send_m('0, 1'b0);
        drain();
        m_axis_tready = 1'b0;
        send_m(24'h123456, 1'b0);
        chk("mid_pre_tvalid", W'(m_axis_tvalid), W'(1));
        aresetn = 1'b1;
        #1;
        chk("mid_rst_tvalid", W'(m_axis_tvalid), '0);
        exp_q.delete();
        cap_q.delete();
        ptr = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        m_axis_tready = 1'b1;
        send_m('0, 1'b0);
        drain();
        if (cap_q.size() >= 1) chk("mid_first_byte", W'(cap_q[0][7:0]), W'(8'h36));
        else chk("mid_count", W'(cap_q.size()), W'(1));

        // Two packets of two zero words.
        do_reset();
        send_m('0, 1'b0);
        send_m('0, 1'b1);
        send_m('0, 1'b0);
        send_m('0, 1'b1);
        drain();
        if (cap_q.size() == 4) begin
`ifdef SCRAMBLER_RESEED_ON_LAST_EN
            chk("pkt_word0_same", cap_q[2], cap_q[0]);
            chk("pkt_word1_same", cap_q[3], cap_q[1]);
`else
            chk_diff("pkt_word0_continues", cap_q[2], cap_q[0]);
            chk("pkt_word2_seq", cap_q[2], seq_word(2 * int'(W)));
`endif
        end else begin
            chk("pkt_count", W'(cap_q.size()), W'(4));
        end

        chk("final_scoreboard_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
